bound_flasher_gen: RTL and testbench



---
 rtl/bound_flasher_pkg.sv | 19 +
 rtl/bf_step_prescaler.sv | 42 ++++
 rtl/bound_flasher_gen.sv | 113 +++++++++++
 tb/tb_bound_flasher_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared state encoding and thermometer decode for the bound flasher lamp sequencer.
package bound_flasher_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP1  = 3'd1,
      DN1  = 3'd2,
      UP2  = 3'd3,
      DN2  = 3'd4,
      UP3  = 3'd5,
      DN3  = 3'd6
   } bf_state_e;

   // One bit of a thermometer bar: lamp idx is lit when idx is below the level.
   function automatic logic therm_bit(input int idx, input int lvl);
      return idx < lvl;
   endfunction

endpackage

// File: rtl/bf_step_prescaler.sv
// Lamp step prescaler: div_cnt runs 0..STEP_DIV-1 while the sequencer is active.
// With BF_HOLD_EN defined, hold_i freezes the count and suppresses the tick.
module bf_step_prescaler
   import bound_flasher_pkg::*;
#(
   parameter int STEP_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active_i,
`ifdef BF_HOLD_EN
   input  logic hold_i,
`endif
   output logic tick_o
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic             run;

`ifdef BF_HOLD_EN
   assign run = active_i & ~hold_i;
`else
   assign run = active_i;
`endif

   assign tick_o = run & (div_cnt_q == DIV_LAST);

   // Idle clears the count, so the first level after a start lasts a full step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else if (!active_i) begin
         div_cnt_q <= '0;
      end else if (run) begin
         div_cnt_q <= tick_o ? '0 : div_cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/bound_flasher_gen.sv
// Parametrised bound flasher: three-bounce thermometer lamp sequence with prescaler,
// busy flag and done pulse. Defining BF_HOLD_EN adds a hold input that freezes the sequence.
module bound_flasher_gen
   import bound_flasher_pkg::*;
#(
   parameter int MX_LP      = 16,
   parameter int KB_LVL     = 6,
   parameter int PEAK_LVL_2 = 11,
   parameter int STEP_DIV   = 1,
   parameter int LVL_W      = $clog2(MX_LP + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flick,
`ifdef BF_HOLD_EN
   input  logic             hold,
`endif
   output logic [MX_LP-1:0] a_lamp,
   output logic [2:0]       a_state,
   output logic             busy,
   output logic             done
);

   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MX_LP);
   localparam logic [LVL_W-1:0] LVL_KB  = LVL_W'(KB_LVL);
   localparam logic [LVL_W-1:0] LVL_PK  = LVL_W'(PEAK_LVL_2);

   bf_state_e        state_q;
   logic [LVL_W-1:0] lvl_q;
   logic [LVL_W-1:0] lvl_step;
   logic [MX_LP-1:0] lamp_q;
   logic [MX_LP-1:0] lamp_d;
   logic             done_q;
   logic             tick;
   logic             up_phase;

   bf_step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .active_i (state_q != IDLE),
`ifdef BF_HOLD_EN
      .hold_i   (hold),
`endif
      .tick_o   (tick)
   );

   // IDLE counts as an up phase so the start edge lands on level 1.
   assign up_phase = (state_q == IDLE) || (state_q == UP1) ||
                     (state_q == UP2)  || (state_q == UP3);
   assign lvl_step = up_phase ? lvl_q + 1'b1 : lvl_q - 1'b1;

   always_comb begin
      lamp_d = '0;
      for (int i = 0; i < MX_LP; i++) begin
         lamp_d[i] = therm_bit(i, int'(lvl_step));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lvl_q   <= '0;
         lamp_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flick) begin
                  state_q <= UP1;
                  lvl_q   <= lvl_step;
                  lamp_q  <= lamp_d;
               end
            end
            UP1, DN1, UP2, DN2, UP3, DN3: begin
               if (tick) begin
                  lvl_q  <= lvl_step;
                  lamp_q <= lamp_d;
                  // Decisions use the stepped level so the turn happens on the same edge.
                  case (state_q)
                     UP1: if (lvl_step == LVL_MAX) state_q <= DN1;
                     DN1: if (lvl_step == LVL_KB)  state_q <= flick ? UP1 : UP2;
                     UP2: if (lvl_step == LVL_PK)  state_q <= DN2;
                     DN2: begin
                        if (lvl_step == LVL_KB && flick) state_q <= UP2;
                        else if (lvl_step == '0)         state_q <= flick ? UP2 : UP3;
                     end
                     UP3: if (lvl_step == LVL_KB)  state_q <= DN3;
                     DN3: begin
                        if (lvl_step == '0) begin
                           state_q <= IDLE;
                           done_q  <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               state_q <= IDLE;
               lvl_q   <= '0;
               lamp_q  <= '0;
            end
         endcase
      end
   end

   assign a_lamp  = lamp_q;
   assign a_state = state_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Scoreboard bench for bound_flasher_gen: two configurations driven against a phase/target
// reference model; builds with or without BF_HOLD_EN.
module tb_bound_flasher_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0, flick_a = 1'b0, flick_b = 1'b0, hold_x = 1'b0;
   logic [15:0] lamp_a;
   logic [7:0]  lamp_b;
   logic [2:0]  st_a, st_b;
   logic        busy_a, busy_b, done_a, done_b;

   bound_flasher_gen dut_a (
      .clk(clk), .rst_n(rst_n), .flick(flick_a),
`ifdef BF_HOLD_EN
      .hold(hold_x),
`endif
      .a_lamp(lamp_a), .a_state(st_a), .busy(busy_a), .done(done_a)
   );

   bound_flasher_gen #(.MX_LP(8), .KB_LVL(2), .PEAK_LVL_2(5), .STEP_DIV(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .flick(flick_b),
`ifdef BF_HOLD_EN
      .hold(hold_x),
`endif
      .a_lamp(lamp_b), .a_state(st_b), .busy(busy_b), .done(done_b)
   );

   int total = 0, bad = 0;
   int cfg_mx[2] = '{16, 8};
   int cfg_kb[2] = '{6, 2};
   int cfg_pk[2] = '{11, 5};
   int cfg_sd[2] = '{1, 3};
   int m_ph[2]   = '{0, 0};
   int m_lvl[2]  = '{0, 0};
   int m_div[2]  = '{0, 0};
   bit m_done[2] = '{0, 0};
   logic [31:0] exp_q_a[$], exp_q_b[$];
   bit mon_en = 1'b0;
   int busy_cnt_a = 0, done_cnt_a = 0;

   // Phases 1..6 alternate up/down; odd phases climb. Each phase ends at a target level.
   task automatic model_step(input int d, input bit rst, input bit fl, input bit hd);
      m_done[d] = 1'b0;
      if (rst) begin
         m_ph[d] = 0; m_lvl[d] = 0; m_div[d] = 0;
      end else if (m_ph[d] == 0) begin
         if (fl) begin m_ph[d] = 1; m_lvl[d] = 1; m_div[d] = 0; end
      end else if (hd) begin
      end else if (m_div[d] != cfg_sd[d] - 1) begin
         m_div[d]++;
      end else begin
         m_div[d] = 0;
         m_lvl[d] += (m_ph[d] % 2 == 1) ? 1 : -1;
         case (m_ph[d])
            1: if (m_lvl[d] == cfg_mx[d]) m_ph[d] = 2;
            2: if (m_lvl[d] == cfg_kb[d]) m_ph[d] = fl ? 1 : 3;
            3: if (m_lvl[d] == cfg_pk[d]) m_ph[d] = 4;
            4: begin
               if (m_lvl[d] == cfg_kb[d] && fl) m_ph[d] = 3;
               else if (m_lvl[d] == 0)          m_ph[d] = fl ? 3 : 5;
            end
            5: if (m_lvl[d] == cfg_kb[d]) m_ph[d] = 6;
            6: if (m_lvl[d] == 0) begin m_ph[d] = 0; m_done[d] = 1'b1; end
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] model_out(input int d);
      logic [63:0] bar;
      logic [2:0]  ph;
      bar = (64'd1 << m_lvl[d]) - 64'd1;
      ph  = 3'(m_ph[d]);
      if (d == 0) return {11'd0, m_done[d], (m_ph[d] != 0), ph, bar[15:0]};
      return {19'd0, m_done[d], (m_ph[d] != 0), ph, bar[7:0]};
   endfunction

   function automatic bit near_kickback(input int d);
      return (m_ph[d] == 2 && m_lvl[d] == cfg_kb[d] + 1) ||
             (m_ph[d] == 4 && (m_lvl[d] == cfg_kb[d] + 1 || m_lvl[d] == 1));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst, input bit fa, input bit fb, input bit hd);
      @(negedge clk);
      rst_n   = ~rst;
      flick_a = fa;
      flick_b = fb;
      hold_x  = hd;
      model_step(0, rst, fa, hd);
      model_step(1, rst, fb, hd);
      exp_q_a.push_back(model_out(0));
      exp_q_b.push_back(model_out(1));
      mon_en = 1'b1;
   endtask

   // Monitor: every edge the DUTs present a new registered output; pop and compare.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow got=empty want=entry at %0t", $time);
         end else begin
            check("dut_a_out", {11'd0, done_a, busy_a, st_a, lamp_a}, exp_q_a.pop_front());
            check("dut_b_out", {19'd0, done_b, busy_b, st_b, lamp_b}, exp_q_b.pop_front());
         end
         if (busy_a === 1'b1) busy_cnt_a++;
         if (done_a === 1'b1) done_cnt_a++;
      end
   end

   initial begin
      int b0, d0, n;
      logic [7:0] snap;
      bit fa, fb, rs, hd;
      int hold_left;

      repeat (3) cycle(1, 0, 0, 0);

      // Single start pulse: 54 edges to completion, busy for 53 samples, one done.
      b0 = busy_cnt_a; d0 = done_cnt_a;
      cycle(0, 1, 1, 0);
      repeat (79) cycle(0, 0, 0, 0);
      @(posedge clk); #2;
      check_int("plain_busy_cycles", busy_cnt_a - b0, 53);
      check_int("plain_done_pulses", done_cnt_a - d0, 1);

      // Flick held through three DN1 kickbacks, then released: 60 extra edges.
      b0 = busy_cnt_a; d0 = done_cnt_a;
      repeat (66) cycle(0, 1, 1, 0);
      repeat (64) cycle(0, 0, 0, 0);
      @(posedge clk); #2;
      check_int("rebounce_busy_cycles", busy_cnt_a - b0, 113);
      check_int("rebounce_done_pulses", done_cnt_a - d0, 1);

      // Reset in the middle of UP2 aborts with no completion pulse.
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      n = 0;
      while (m_ph[0] != 3 && n < 100) begin cycle(0, 0, 0, 0); n++; end
      cycle(0, 0, 0, 0);
      @(posedge clk); #2;
      check("mid_up2_state", {29'd0, st_a}, 32'd3);
      d0 = done_cnt_a;
      cycle(1, 0, 0, 0);
      @(posedge clk); #2;
      check("rst_lamp", {16'd0, lamp_a}, 32'd0);
      check("rst_state", {29'd0, st_a}, 32'd0);
      cycle(0, 0, 0, 0);
      @(posedge clk); #2;
      check_int("rst_no_done", done_cnt_a - d0, 0);

`ifdef BF_HOLD_EN
      // Freeze dut_b mid-DN1 for 10 cycles; the bar must not move.
      cycle(0, 0, 1, 0);
      n = 0;
      while (m_ph[1] != 2 && n < 100) begin cycle(0, 0, 0, 0); n++; end
      cycle(0, 0, 0, 0);
      @(posedge clk); #2;
      snap = lamp_b;
      repeat (10) begin
         cycle(0, 0, 1, 1);
         @(posedge clk); #2;
         check("hold_frozen", {24'd0, lamp_b}, {24'd0, snap});
      end
`endif

      // Randomised run: flick biased toward kickback points, hold bursts, rare resets.
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         fa = near_kickback(0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
         fb = near_kickback(1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
         rs = ($urandom_range(0, 299) == 0);
`ifdef BF_HOLD_EN
         if (hold_left == 0 && $urandom_range(0, 39) == 0) hold_left = $urandom_range(1, 10);
`endif
         hd = (hold_left > 0);
         if (hold_left > 0) hold_left--;
         cycle(rs, fa, fb, hd);
      end

      @(posedge clk); #3;
      mon_en = 1'b0;
      check_int("sb_drain_a", exp_q_a.size(), 0);
      check_int("sb_drain_b", exp_q_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
